// File: rtl/tdm_demux16.sv
// TDM demultiplexer: gathers 16 time-slot samples into a frame and offers it on a valid/ready port.
// Optional sticky frame-loss flag 'overrun' is built when TDM_DEMUX16_OVERRUN_EN is defined.
module tdm_demux16 #(
  parameter int WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  input  logic                  in_sync,
  output logic [16*WIDTH-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            slot,
`ifdef TDM_DEMUX16_OVERRUN_EN
  output logic                  overrun,
`endif
  output logic                  dbg_state_o
);

  // Output handshake: a frame transfers on any cycle where out_valid and out_ready are both 1.
  // out_valid stays high and out_data stays stable until that transfer; the input side never stalls.

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  state_e                state_q;
  logic [3:0]            slot_q;
  logic [16*WIDTH-1:0]   shadow_q;
  logic [16*WIDTH-1:0]   shadow_d;
  logic [16*WIDTH-1:0]   out_data_q;
  logic                  out_valid_q;
  logic [3:0]            wr_idx;
  logic                  wr_en;
  logic                  frame_done;
  logic                  accept;
  logic                  load;

  always_comb begin
    wr_idx     = in_sync ? 4'd0 : slot_q;
    wr_en      = in_valid && (in_sync || (state_q == COLLECT));
    frame_done = wr_en && !in_sync && (slot_q == 4'd15);
    shadow_d   = shadow_q;
    if (wr_en) begin
      shadow_d[int'(wr_idx)*WIDTH +: WIDTH] = in_data;
    end
    accept     = out_valid_q && out_ready;
    // A completed frame is dropped when the previous one is still pending and not taken now.
    load       = frame_done && (!out_valid_q || out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      slot_q      <= 4'd0;
      shadow_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      if (in_sync) begin
        state_q <= COLLECT;
        slot_q  <= {3'b000, in_valid};
      end else if ((state_q == COLLECT) && in_valid) begin
        slot_q <= slot_q + 4'd1;
      end
      if (load) begin
        out_data_q  <= shadow_d;
        out_valid_q <= 1'b1;
      end else if (accept) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef TDM_DEMUX16_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (frame_done && out_valid_q && !out_ready) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`endif

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign slot        = slot_q;
  assign dbg_state_o = (state_q == COLLECT);

endmodule

// File: tb/tb_tdm_demux16.sv
// Bench for tdm_demux16 (WIDTH=4): directed frame scenarios plus random traffic against a queue-based frame model.
module tb_tdm_demux16;
  localparam int W = 4;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_sync;
  logic [63:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    slot;
  logic          dbg_state;
`ifdef TDM_DEMUX16_OVERRUN_EN
  logic          overrun;
`endif

  tdm_demux16 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_sync     (in_sync),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .slot        (slot),
`ifdef TDM_DEMUX16_OVERRUN_EN
    .overrun     (overrun),
`endif
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: samples of the frame in progress, plus the output buffer
  logic [W-1:0]  cur_q[$];
  logic [63:0]   exp_q[$];
  bit            m_hunt;
  bit            m_ov;
  bit            m_overrun;
  logic [63:0]   m_out;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    cur_q.delete();
    exp_q.delete();
    m_hunt    = 1'b1;
    m_ov      = 1'b0;
    m_overrun = 1'b0;
    m_out     = '0;
  endtask

  task automatic model_step(input bit v, input bit s, input logic [W-1:0] d, input bit r);
    bit          done;
    logic [63:0] f;
    done = 1'b0;
    f    = '0;
    if (s) begin
      cur_q.delete();
      m_hunt = 1'b0;
      if (v) cur_q.push_back(d);
    end else if (v && !m_hunt) begin
      cur_q.push_back(d);
      if (cur_q.size() == 16) begin
        for (int i = 0; i < 16; i++) f[i*W +: W] = cur_q[i];
        cur_q.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (!m_ov || r) begin
        m_out = f;
        m_ov  = 1'b1;
        exp_q.push_back(f);
      end else begin
        m_overrun = 1'b1;
      end
    end else if (m_ov && r) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic compare_outputs(input string tag);
    check({tag, ".slot"},      {60'd0, slot},      64'(cur_q.size()));
    check({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, m_ov});
    check({tag, ".out_data"},  out_data,           m_out);
    check({tag, ".state"},     {63'd0, dbg_state}, {63'd0, !m_hunt});
`ifdef TDM_DEMUX16_OVERRUN_EN
    check({tag, ".overrun"},   {63'd0, overrun},   {63'd0, m_overrun});
`endif
  endtask

  // driver: one clock cycle of input
  task automatic step(input bit v, input bit s, input logic [W-1:0] d, input bit r);
    @(negedge clk);
    in_valid  = v;
    in_sync   = s;
    in_data   = d;
    out_ready = r;
    #1;
    if (out_valid && r && exp_q.size() != 0) check("accepted_frame", out_data, exp_q.pop_front());
    model_step(v, s, d, r);
    @(posedge clk);
    #1;
    compare_outputs("cyc");
  endtask

  task automatic send_frame(input logic [63:0] f, input bit r_other, input bit r_last);
    for (int i = 0; i < 16; i++) step(1'b1, i == 0, f[i*W +: W], (i == 15) ? r_last : r_other);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst.out_valid", {63'd0, out_valid}, 64'd0);
    check("rst.out_data",  out_data,           64'd0);
    check("rst.slot",      {60'd0, slot},      64'd0);
    check("rst.state",     {63'd0, dbg_state}, 64'd0);
`ifdef TDM_DEMUX16_OVERRUN_EN
    check("rst.overrun",   {63'd0, overrun},   64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [63:0] fa;
  logic [63:0] fb;

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_sync   = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #3;
    check("por.out_valid", {63'd0, out_valid}, 64'd0);
    check("por.slot",      {60'd0, slot},      64'd0);
    #20;
    rst_n = 1'b1;

    // samples before any sync are discarded
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 4'(i), 1'b1);
    check("hunt.slot", {60'd0, slot}, 64'd0);

    // 0..15 frame, output one cycle after the last sample
    send_frame(64'hFEDCBA9876543210, 1'b0, 1'b0);
    check("seq.out_valid", {63'd0, out_valid}, 64'd1);
    check("seq.out_data",  out_data, 64'hFEDCBA9876543210);
    step(1'b0, 1'b0, 4'd0, 1'b1);

    // resync after 7 samples: partial frame absent
    for (int i = 0; i < 7; i++) step(1'b1, i == 0, 4'h5, 1'b0);
    send_frame({16{4'hA}}, 1'b0, 1'b0);
    check("resync.out_data", out_data, {16{4'hA}});
    step(1'b0, 1'b0, 4'd0, 1'b1);

    // two frames without ready: first held, second dropped
    fa = {$urandom, $urandom};
    fb = ~fa;
    send_frame(fa, 1'b0, 1'b0);
    send_frame(fb, 1'b0, 1'b0);
    check("hold.out_data", out_data, fa);
`ifdef TDM_DEMUX16_OVERRUN_EN
    check("hold.overrun", {63'd0, overrun}, 64'd1);
`endif
    step(1'b0, 1'b0, 4'd0, 1'b1);

    // acceptance on the completion cycle of the next frame
    async_reset();
    fa = {$urandom, $urandom};
    fb = {$urandom, $urandom};
    send_frame(fa, 1'b0, 1'b0);
    send_frame(fb, 1'b0, 1'b1);
    check("b2b.out_valid", {63'd0, out_valid}, 64'd1);
    check("b2b.out_data",  out_data, fb);
    step(1'b0, 1'b0, 4'd0, 1'b1);

    // reset mid-frame at slot 9, then only sync restarts collection
    for (int i = 0; i < 9; i++) step(1'b1, i == 0, 4'($urandom), 1'b0);
    check("mid.slot", {60'd0, slot}, 64'd9);
    async_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'($urandom), 1'b1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
           4'($urandom), $urandom_range(0, 2) != 0);
      if (i == 1500) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
